// File: rtl/lfo_del_mod.sv
// Triangle LFO producing the per-sample delay tap for var_del: phase accumulator,
// triangle fold and depth scale, then base offset and clamp to the buffer range.
module lfo_del_mod #(
  parameter  int PHASE_W    = 20,
  parameter  int TRI_W      = 8,
  parameter  int BUFR_DEPTH = 512,
  localparam int ADDR_W     = $clog2(BUFR_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_i,
  input  logic                sync_i,
  input  logic                hold_i,
  input  logic [PHASE_W-1:0]  rate_i,
  input  logic [ADDR_W-1:0]   depth_i,
  input  logic [ADDR_W-1:0]   base_i,
  output logic [ADDR_W-1:0]   del_o,
  output logic                vld_o
);

  localparam int                PROD_W  = TRI_W + ADDR_W;
  localparam logic [ADDR_W-1:0] DEL_MAX = ADDR_W'(BUFR_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEL_MIN = ADDR_W'(1);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t               state_q,   state_d;
  logic [PHASE_W-1:0]   phase_q,   phase_d;
  logic                 pend_q,    pend_d;
  logic [PHASE_W-1:0]   rate_s_q,  rate_s_d;
  logic [ADDR_W-1:0]    depth_s_q, depth_s_d;
  logic [ADDR_W-1:0]    base_s_q,  base_s_d;
  logic                 v1_q,      v1_d;
  logic [ADDR_W-1:0]    depth1_q,  depth1_d;
  logic [ADDR_W-1:0]    base1_q,   base1_d;
  logic                 v2_q,      v2_d;
  logic [ADDR_W-1:0]    scaled2_q, scaled2_d;
  logic [ADDR_W-1:0]    base2_q,   base2_d;
  logic                 v3_q,      v3_d;
  logic [ADDR_W-1:0]    del_q,     del_d;

  logic                 sync_eff;
  logic                 reload;
  logic [PHASE_W-1:0]   rate_eff;
  logic [PHASE_W:0]     phase_sum;
  logic [TRI_W-1:0]     u_val;
  logic [TRI_W-1:0]     tri_val;
  logic [PROD_W-1:0]    prod;
  logic [ADDR_W:0]      sum3;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pend_d    = pend_q;
    rate_s_d  = rate_s_q;
    depth_s_d = depth_s_q;
    base_s_d  = base_s_q;
    depth1_d  = depth1_q;
    base1_d   = base1_q;
    v1_d      = vld_i;
    reload    = 1'b0;

    // The first sample after reset runs on the live inputs; later ones on the shadows.
    sync_eff  = sync_i | pend_q;
    rate_eff  = (state_q == ST_LOAD) ? rate_i : rate_s_q;
    phase_sum = {1'b0, phase_q} + {1'b0, rate_eff};

    if (vld_i) begin
      pend_d   = 1'b0;
      state_d  = ST_RUN;
      depth1_d = (state_q == ST_LOAD) ? depth_i : depth_s_q;
      base1_d  = (state_q == ST_LOAD) ? base_i  : base_s_q;
      reload   = (state_q == ST_LOAD);
      if (sync_eff) begin
        phase_d = '0;
        reload  = 1'b1;
      end else if (!hold_i) begin
        phase_d = phase_sum[PHASE_W-1:0];
        reload  = reload | phase_sum[PHASE_W];
      end
      if (reload) begin
        rate_s_d  = rate_i;
        depth_s_d = depth_i;
        base_s_d  = base_i;
      end
    end else if (sync_i) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    u_val     = phase_q[PHASE_W-2 -: TRI_W];
    tri_val   = phase_q[PHASE_W-1] ? ~u_val : u_val;
    prod      = PROD_W'(tri_val) * PROD_W'(depth1_q);
    scaled2_d = ADDR_W'(prod >> TRI_W);
    base2_d   = base1_q;
    v2_d      = v1_q;

    sum3 = {1'b0, base2_q} + {1'b0, scaled2_q};
    v3_d = v2_q;
    del_d = del_q;
    if (v2_q) begin
      if (sum3[ADDR_W])                  del_d = DEL_MAX;
      else if (sum3[ADDR_W-1:0] == '0)   del_d = DEL_MIN;
      else                               del_d = sum3[ADDR_W-1:0];
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      phase_q   <= '0;
      pend_q    <= 1'b0;
      rate_s_q  <= '0;
      depth_s_q <= '0;
      base_s_q  <= '0;
      v1_q      <= 1'b0;
      depth1_q  <= '0;
      base1_q   <= '0;
      v2_q      <= 1'b0;
      scaled2_q <= '0;
      base2_q   <= '0;
      v3_q      <= 1'b0;
      del_q     <= DEL_MIN;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      rate_s_q  <= rate_s_d;
      depth_s_q <= depth_s_d;
      base_s_q  <= base_s_d;
      v1_q      <= v1_d;
      depth1_q  <= depth1_d;
      base1_q   <= base1_d;
      v2_q      <= v2_d;
      scaled2_q <= scaled2_d;
      base2_q   <= base2_d;
      v3_q      <= v3_d;
      del_q     <= del_d;
    end
  end

  assign del_o = del_q;
  assign vld_o = v3_q;

endmodule

// File: tb/tb_lfo_del_mod.sv
// Randomised bench for lfo_del_mod: a behavioural LFO model pushes expected taps into
// a scoreboard queue; a negedge monitor pops and compares on every vld_o.
module tb_lfo_del_mod;

  localparam int PW    = 20;
  localparam int TW    = 8;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam longint PMOD = longint'(1) << PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld_i, sync_i, hold_i;
  logic [PW-1:0] rate_i;
  logic [AW-1:0] depth_i, base_i;
  logic [AW-1:0] del_o;
  logic          vld_o;

  lfo_del_mod #(.PHASE_W(PW), .TRI_W(TW), .BUFR_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .vld_i(vld_i), .sync_i(sync_i), .hold_i(hold_i),
    .rate_i(rate_i), .depth_i(depth_i), .base_i(base_i), .del_o(del_o), .vld_o(vld_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int del; int cyc; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int last_del = 1;
  bit in_reset = 1'b1;
  bit mon_en = 1'b0;

  // Reference model state: oscillator phase plus the parameter set the oscillator is running on.
  longint m_phase;
  bit     m_started, m_pend;
  longint m_rate;
  int     m_depth, m_base;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Triangle of one full period mapped onto 2*2^TW segments, scaled, offset and clamped.
  function automatic int model_del(longint ph, int d, int b);
    longint seg_len = longint'(1) << (PW - 1 - TW);
    int pos  = int'(ph / seg_len);
    int peak = (1 << TW) - 1;
    int tri_v = (pos <= peak) ? pos : (2 * peak + 1 - pos);
    int s    = b + (tri_v * d) / (1 << TW);
    if (s < 1) s = 1;
    if (s > DEPTH - 1) s = DEPTH - 1;
    return s;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_started = 0; m_pend = 0;
    m_rate = 0; m_depth = 0; m_base = 0;
  endfunction

  // Returns the expected tap for a sample issued with the current inputs.
  function automatic int model_sample(bit s, bit h);
    longint r; int d, b; bit do_sync, reload;
    do_sync = s | m_pend;
    m_pend  = 0;
    reload  = 0;
    if (!m_started) begin
      r = longint'(rate_i); d = int'(depth_i); b = int'(base_i);
      reload = 1; m_started = 1;
    end else begin
      r = m_rate; d = m_depth; b = m_base;
    end
    if (do_sync) begin
      m_phase = 0; reload = 1;
    end else if (!h) begin
      if (m_phase + r >= PMOD) reload = 1;
      m_phase = (m_phase + r) % PMOD;
    end
    if (reload) begin
      m_rate = longint'(rate_i); m_depth = int'(depth_i); m_base = int'(base_i);
    end
    return model_del(m_phase, d, b);
  endfunction

  task automatic step(input bit v, input bit s, input bit h);
    exp_t e;
    vld_i = v; sync_i = s; hold_i = h;
    if (v) begin
      e.del = model_sample(s, h);
      e.cyc = cyc + 3;
      sb_q.push_back(e);
    end else if (s) begin
      m_pend = 1;
    end
    @(posedge clk); #1;
    vld_i = 0; sync_i = 0; hold_i = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    in_reset = 1; rst = 0;
    vld_i = 0; sync_i = 0; hold_i = 0;
    repeat (n) @(posedge clk);
    #1;
    sb_q.delete();
    model_reset();
    check("reset_del_o", int'(del_o), 1);
    check("reset_vld_o", int'(vld_o), 0);
    rst = 1;
    last_del = 1;
    in_reset = 0;
  endtask

  task automatic set_params(input int r, input int d, input int b);
    rate_i = PW'(r); depth_i = AW'(d); base_i = AW'(b);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (vld_o) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_vld_o: got del_o=%0d, expected no output (cycle %0d)", del_o, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("del_o", int'(del_o), e.del);
          check("latency", cyc, e.cyc);
          last_del = e.del;
        end
      end else if (!in_reset) begin
        check("del_hold", int'(del_o), last_del);
      end
    end
  end

  initial begin
    rst = 0; vld_i = 0; sync_i = 0; hold_i = 0;
    set_params(0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    mon_en = 1;

    // Static delay
    do_reset(2);
    set_params(0, 0, 5);
    run(20);

    // Triangle over slightly more than one period
    do_reset(2);
    set_params(4096, 256, 10);
    run(300);

    // Clamp at the top, then at the bottom once a sync reloads base=0/depth=0
    do_reset(1);
    set_params(65536, 100, 500);
    run(40);
    set_params(65536, 0, 0);
    step(1'b1, 1'b1, 1'b0);
    run(10);

    // Wrap-synchronous reload of rate, then of depth
    do_reset(1);
    set_params(4096, 256, 10);
    run(100);
    set_params(8192, 256, 10);
    run(300);
    set_params(8192, 100, 10);
    run(200);

    // Sync with strobe, sync pending across idle cycles, hold, sync+hold
    set_params(8192, 300, 20);
    run(37);
    step(1'b1, 1'b1, 1'b0);
    run(5);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run(20);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    run(5);
    step(1'b1, 1'b1, 1'b1);
    run(5);

    // Reset with two samples in flight
    run(2);
    do_reset(1);
    set_params(4096, 256, 10);
    run(20);

    // Gapped strobes, one every 4th cycle
    do_reset(1);
    set_params(4096, 256, 10);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end

    // Random traffic with random parameters, syncs, holds and one reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)
        set_params(int'($urandom_range(0, 1 << 17)), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, DEPTH - 1)));
      if (i == 1500) do_reset(1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
    end

    // Drain, bounded
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d outputs outstanding, expected 0", sb_q.size());
    end
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
